// File: rtl/param_mod_counter_if.sv
// Control and status bundle for param_mod_counter.
interface param_mod_counter_if #(
   parameter int unsigned WIDTH = 8
);

   logic             enable;
   logic             up;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap;

   // Controller side: drives controls, observes count status.
   modport master (
      output enable, up, clear, load, load_val,
      input  count, tc, wrap
   );

   // Counter side: consumes controls, presents count status.
   modport slave (
      input  enable, up, clear, load, load_val,
      output count, tc, wrap
   );

endinterface

// File: rtl/param_mod_counter.sv
// Modulo-N up/down counter with prescaled enable, clamped parallel load,
// terminal-count flag and a one-cycle wrap pulse.
module param_mod_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MODULUS  = 256,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   param_mod_counter_if.slave   bus
);

   localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned EXT_W = WIDTH + 1;

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
   localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULUS);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [PS_W-1:0]  ps_q;
   logic [PS_W-1:0]  ps_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             load_in_range_c;

   // Load values at or above the modulus clamp to the top count.
   assign load_in_range_c = ({1'b0, bus.load_val} < MOD_EXT);

   // Next-state: clear beats load beats a prescaled step beats hold.
   always_comb begin
      count_d = count_q;
      ps_d    = ps_q;
      wrap_d  = 1'b0;
      if (bus.clear) begin
         count_d = '0;
         ps_d    = '0;
      end else if (bus.load) begin
         count_d = load_in_range_c ? bus.load_val : MAX_CNT;
         ps_d    = '0;
      end else if (bus.enable) begin
         if (ps_q == PS_LAST) begin
            ps_d = '0;
            if (bus.up) begin
               if (count_q == MAX_CNT) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end else begin
               if (count_q == '0) begin
                  count_d = MAX_CNT;
                  wrap_d  = 1'b1;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
         end else begin
            ps_d = ps_q + 1'b1;
         end
      end
   end

   // State registers; reset discards any in-flight prescale or wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         ps_q    <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ps_q    <= ps_d;
         wrap_q  <= wrap_d;
      end
   end

   // Terminal count follows the live direction input without delay.
   assign bus.tc    = bus.up ? (count_q == MAX_CNT) : (count_q == '0);
   assign bus.count = count_q;
   assign bus.wrap  = wrap_q;

endmodule

// File: doc/param_mod_counter.md
PARAM_MOD_COUNTER -- requirements
Module: param_mod_counter

Interface
REQ-001 Parameter WIDTH, default 8, count register width in bits.
REQ-002 Parameter MODULUS, default 256, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter PRESCALE, default 1, qualified enable cycles per count step; legal range >= 1.
REQ-004 Port clk  input  1  clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port enable  input  1  advances the prescaler while high.
REQ-007 Port up  input  1  direction select: 1 = increment, 0 = decrement.
REQ-008 Port clear  input  1  synchronous clear of count and prescaler.
REQ-009 Port load  input  1  synchronous parallel load of count from load_val.
REQ-010 Port load_val  input  WIDTH  value loaded when load is high.
REQ-011 Port count  output  WIDTH  registered count value.
REQ-012 Port tc  output  1  terminal count, combinational from count and up.
REQ-013 Port wrap  output  1  registered one-cycle pulse flagging a wrap step.

Function
REQ-014 Per-cycle priority SHALL be clear > load > step > hold.
REQ-015 clear high: count <= 0, prescaler <= 0, wrap <= 0; enable and load ignored.
REQ-016 load high, clear low: count <= load_val if load_val < MODULUS, else MODULUS-1; prescaler <= 0; wrap <= 0.
REQ-017 Prescaler SHALL count enable-high cycles from 0 to PRESCALE-1, then return to 0; enable low holds it.
REQ-018 A step SHALL occur in a cycle with enable high, clear and load low, and prescaler == PRESCALE-1; PRESCALE = 1 steps on every enabled cycle.
REQ-019 Up step: count <= count+1; at count == MODULUS-1, count <= 0 instead.
REQ-020 Down step: count <= count-1; at count == 0, count <= MODULUS-1 instead.
REQ-021 wrap SHALL be 1 for exactly the cycle after a step that took the REQ-019/REQ-020 wrap path, and 0 in all other cycles.
REQ-022 tc SHALL be 1 when (up=1 and count==MODULUS-1) or (up=0 and count==0), and follow up with no cycle delay.
REQ-023 No step: count SHALL hold its value; enable low never modifies count.
REQ-024 Arithmetic SHALL be modulo MODULUS; count SHALL never hold a value >= MODULUS.
REQ-025 If up changes mid-prescale, the prescaler is not reset; the next step uses the current up value.

Reset
REQ-026 rst_n low SHALL immediately force count = 0, prescaler = 0, wrap = 0, independent of clk.
REQ-027 After rst_n goes high, the first step SHALL need a full PRESCALE enabled cycles.
REQ-028 Reset asserted mid-prescale or mid-wrap-pulse SHALL discard all in-flight state.

Verification
Use WIDTH=4, MODULUS=10, PRESCALE=1 unless stated.
REQ-029 Reset, up=1, enable=1 for 12 cycles -> count 1..9,0,1,2; wrap high one cycle after count 9->0; tc high while count=9.
REQ-030 up=0, enable=1 from count=0 -> count 9,8,...; wrap pulses after 0->9; tc high at count=0.
REQ-031 load=1, load_val=13 -> count=9; load_val=5 with clear=1 in the same cycle -> count=0.
REQ-032 PRESCALE=3, enable held high from reset -> count increments every 3rd cycle; enable low for 2 cycles mid-prescale -> step delayed by exactly 2 cycles.
REQ-033 MODULUS=16 (full range), up=1 -> count 15->0 with wrap pulse; count never exceeds 15.
REQ-034 rst_n pulsed low between clock edges at count=7 -> count=0 immediately; wrap=0; counting resumes from 0 after release.
